// File: rtl/sidi_audio_pkg.sv
// Shared helpers for the SiDi audio output stage: midscale, offset-binary conversion, limits.
// Latency: n/a (pure functions and constants).
// Backpressure: n/a.
package sidi_audio_pkg;

  // Ceiling of the saturating underrun counter.
  localparam int unsigned UNDERRUN_MAX = 255;

  // Midscale code (1 << (width-1)) of an offset-binary word of the given width.
  function automatic logic [31:0] midscale(input int unsigned width);
    return 32'(1) << (width - 1);
  endfunction

  // Two's complement to offset binary: invert the sign bit of a width-bit value.
  function automatic logic [31:0] to_offset_bin(input logic [31:0] v, input int unsigned width);
    return v ^ (32'(1) << (width - 1));
  endfunction

endpackage

// File: rtl/sidi_sd_chan.sv
// One channel's sigma-delta modulator; SIDI_AUDIO_SECOND_ORDER_EN selects second order.
// Latency: target change reaches pdm one cycle after it is seen (registered output).
// Backpressure: none, free-running every clk_sys cycle.
module sidi_sd_chan #(
  parameter int DAC_WIDTH = 11
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [DAC_WIDTH-1:0] target,
  output logic                 pdm
);

`ifdef SIDI_AUDIO_SECOND_ORDER_EN
  localparam int W = DAC_WIDTH + 3;

  logic signed [W-1:0] i1_q, i2_q;
  logic signed [W-1:0] tgt_s, fb, i1_nx, i2_nx;

  // Feedback is full scale minus one when the last bit was high, so density tracks target.
  assign tgt_s = $signed({3'b000, target});
  assign fb    = pdm ? $signed({3'b000, {DAC_WIDTH{1'b1}}}) : '0;
  assign i1_nx = i1_q + tgt_s - fb;
  assign i2_nx = i2_q + i1_nx - fb;

  // Two cascaded error-feedback integrators; output bit is the sign of the second.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      i1_q <= '0;
      i2_q <= '0;
      pdm  <= 1'b0;
    end else begin
      i1_q <= i1_nx;
      i2_q <= i2_nx;
      pdm  <= ~i2_nx[W-1];
    end
  end
`else
  logic [DAC_WIDTH-1:0] acc_q;
  logic [DAC_WIDTH:0]   sum;

  // Carry out of the accumulator is the density-modulated bit.
  assign sum = {1'b0, acc_q} + {1'b0, target};

  // First-order phase accumulator with registered carry.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc_q <= '0;
      pdm   <= 1'b0;
    end else begin
      acc_q <= sum[DAC_WIDTH-1:0];
      pdm   <= sum[DAC_WIDTH];
    end
  end
`endif

endmodule

// File: rtl/sidi_audio_out.sv
// N-channel audio output: frame holding register, tick-paced DAC load, per-channel sigma-delta.
// Latency: accept to dac_out at most OSR_DIV+1 cycles; pdm follows dac_out one cycle later.
// Backpressure: s_ready drops while a frame is pending and rises the cycle after it is loaded.
// Build option: define SIDI_AUDIO_SECOND_ORDER_EN for second-order modulators.
module sidi_audio_out
  import sidi_audio_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int IN_WIDTH  = 16,
  parameter int DAC_WIDTH = 11,
  parameter int OSR_DIV   = 4
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [CHANNELS*IN_WIDTH-1:0]  s_data,
  input  logic [3:0]                    atten,
  input  logic                          mute,
  output logic [CHANNELS-1:0]           pdm_out,
  output logic [CHANNELS*DAC_WIDTH-1:0] dac_out,
  output logic                          dac_strobe,
  output logic [7:0]                    underrun_cnt
);

  localparam int CNT_W = (OSR_DIV > 2) ? $clog2(OSR_DIV) : 1;
  localparam logic [DAC_WIDTH-1:0] MID = DAC_WIDTH'(midscale(DAC_WIDTH));

  logic [CNT_W-1:0]              cnt_q;
  logic                          tick, accept, load;
  logic                          pend_q, pend_d;
  logic [CHANNELS*IN_WIDTH-1:0]  hold_q;
  logic [CHANNELS*DAC_WIDTH-1:0] target_q, load_val;

  assign tick   = (cnt_q == CNT_W'(OSR_DIV - 1));
  assign accept = s_valid && s_ready;
  // Load uses pend as it stood at the start of the cycle, so a same-cycle accept waits a tick.
  assign load   = tick && pend_q;

  // Next pending state: a load clears it, an accept sets it (they cannot coincide).
  always_comb begin
    pend_d = pend_q;
    if (load)   pend_d = 1'b0;
    if (accept) pend_d = 1'b1;
  end

  // Sample-rate divider wrapping at OSR_DIV-1.
  always_ff @(posedge clk_sys) begin
    if (reset)     cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + CNT_W'(1);
  end

  // Single-frame holding register with registered ready.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_q  <= 1'b0;
      s_ready <= 1'b0;
      hold_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      s_ready <= ~pend_d;
      if (accept) hold_q <= s_data;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [IN_WIDTH-1:0] shifted;

    assign shifted = $signed(hold_q[c*IN_WIDTH +: IN_WIDTH]) >>> atten;
    // Top DAC_WIDTH bits of the offset-binary sample, or midscale when muted.
    assign load_val[c*DAC_WIDTH +: DAC_WIDTH] = mute ? MID :
      DAC_WIDTH'(to_offset_bin(32'(shifted), IN_WIDTH) >> (IN_WIDTH - DAC_WIDTH));

    sidi_sd_chan #(.DAC_WIDTH(DAC_WIDTH)) u_sd (
      .clk_sys (clk_sys),
      .reset   (reset),
      .target  (target_q[c*DAC_WIDTH +: DAC_WIDTH]),
      .pdm     (pdm_out[c])
    );
  end

  // DAC word load, strobe and underrun accounting on each tick.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      target_q     <= {CHANNELS{MID}};
      dac_strobe   <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      dac_strobe <= load;
      if (load) target_q <= load_val;
      if (tick && !pend_q && underrun_cnt != 8'(UNDERRUN_MAX))
        underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

  assign dac_out = target_q;

endmodule

// File: tb/tb_sidi_audio_out.sv
// Directed bench for sidi_audio_out (CHANNELS=2, IN_WIDTH=16, DAC_WIDTH=11, OSR_DIV=4).
// Inputs change and outputs are sampled 1ns after each rising clk_sys edge.
// Define SIDI_AUDIO_SECOND_ORDER_EN to match a second-order build.
module tb_sidi_audio_out;

  localparam int CH = 2, IW = 16, DW = 11, OSR = 4;

  logic             clk_sys = 1'b0;
  logic             reset;
  logic             s_valid;
  logic             s_ready;
  logic [CH*IW-1:0] s_data;
  logic [3:0]       atten;
  logic             mute;
  logic [CH-1:0]    pdm_out;
  logic [CH*DW-1:0] dac_out;
  logic             dac_strobe;
  logic [7:0]       underrun_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk_sys = ~clk_sys;

  sidi_audio_out #(.CHANNELS(CH), .IN_WIDTH(IW), .DAC_WIDTH(DW), .OSR_DIV(OSR)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .atten        (atten),
    .mute         (mute),
    .pdm_out      (pdm_out),
    .dac_out      (dac_out),
    .dac_strobe   (dac_strobe),
    .underrun_cnt (underrun_cnt)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Leaves the bench 1ns after the last reset edge with reset just released.
  task automatic do_reset();
    reset = 1'b1; s_valid = 1'b0; s_data = '0; atten = 4'd0; mute = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b1; s_data = {16'h7FFF, 16'h7FFF}; atten = 4'd0; mute = 1'b0;
    step(3);
    checks++; if (pdm_out !== 2'b00) begin failures++; $display("FAIL rst_pdm got=%b exp=00", pdm_out); end
    checks++; if (dac_out !== {11'h400, 11'h400}) begin failures++; $display("FAIL rst_dac got=%h exp=%h", dac_out, {11'h400, 11'h400}); end
    checks++; if (underrun_cnt !== 8'd0) begin failures++; $display("FAIL rst_underrun got=%0d exp=0", underrun_cnt); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", s_ready); end
    checks++; if (dac_strobe !== 1'b0) begin failures++; $display("FAIL rst_strobe got=%b exp=0", dac_strobe); end
    reset = 1'b0; s_valid = 1'b0;
    step(1);
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_rise got=%b exp=1", s_ready); end
    // First tick lands on the fourth edge after release; the frame seen in reset must not load.
    step(3);
    checks++; if (dac_strobe !== 1'b0) begin failures++; $display("FAIL rst_no_load got=%b exp=0", dac_strobe); end
    checks++; if (underrun_cnt !== 8'd1) begin failures++; $display("FAIL rst_first_tick got=%0d exp=1", underrun_cnt); end
  endtask

  task automatic test_full_scale();
    int ones0, ones1;
    do_reset();
    s_data = {16'h8000, 16'h7FFF}; s_valid = 1'b1;
    step(2);
    s_valid = 1'b0;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL fs_ready_low got=%b exp=0", s_ready); end
    step(1);
    checks++; if (dac_strobe !== 1'b0) begin failures++; $display("FAIL fs_early_strobe got=%b exp=0", dac_strobe); end
    step(1);
    checks++; if (dac_strobe !== 1'b1) begin failures++; $display("FAIL fs_strobe got=%b exp=1", dac_strobe); end
    checks++; if (dac_out !== {11'h000, 11'h7FF}) begin failures++; $display("FAIL fs_dac got=%h exp=%h", dac_out, {11'h000, 11'h7FF}); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL fs_ready_high got=%b exp=1", s_ready); end
    step(1);
    checks++; if (dac_strobe !== 1'b0) begin failures++; $display("FAIL fs_strobe_pulse got=%b exp=0", dac_strobe); end
    step(2);
    ones0 = 0; ones1 = 0;
    for (int i = 0; i < 2048; i++) begin
      ones0 += int'(pdm_out[0]);
      ones1 += int'(pdm_out[1]);
      step(1);
    end
`ifdef SIDI_AUDIO_SECOND_ORDER_EN
    checks++; if (ones0 < 2046) begin failures++; $display("FAIL fs_density0 got=%0d exp>=2046", ones0); end
    checks++; if (ones1 > 1) begin failures++; $display("FAIL fs_density1 got=%0d exp<=1", ones1); end
`else
    checks++; if (ones0 != 2047) begin failures++; $display("FAIL fs_density0 got=%0d exp=2047", ones0); end
    checks++; if (ones1 != 0) begin failures++; $display("FAIL fs_density1 got=%0d exp=0", ones1); end
`endif
  endtask

  task automatic test_backpressure();
    do_reset();
    s_data = {16'hF000, 16'h1234}; s_valid = 1'b1;
    step(2);
    s_data = {16'hC000, 16'h0000};
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_a got=%b exp=0", s_ready); end
    step(1);
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_hold got=%b exp=0", s_ready); end
    step(1);
    checks++; if (dac_out !== {11'h380, 11'h491}) begin failures++; $display("FAIL bp_dac_a got=%h exp=%h", dac_out, {11'h380, 11'h491}); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%b exp=1", s_ready); end
    step(1);
    s_valid = 1'b0;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_b got=%b exp=0", s_ready); end
    checks++; if (dac_out !== {11'h380, 11'h491}) begin failures++; $display("FAIL bp_dac_hold got=%h exp=%h", dac_out, {11'h380, 11'h491}); end
    step(3);
    checks++; if (dac_strobe !== 1'b1) begin failures++; $display("FAIL bp_strobe_b got=%b exp=1", dac_strobe); end
    checks++; if (dac_out !== {11'h200, 11'h400}) begin failures++; $display("FAIL bp_dac_b got=%h exp=%h", dac_out, {11'h200, 11'h400}); end
  endtask

  task automatic test_mute();
    logic [CH-1:0] prev;
    do_reset();
    mute = 1'b1; s_data = {16'h7FFF, 16'h7FFF}; s_valid = 1'b1;
    step(2);
    s_valid = 1'b0;
    step(2);
    mute = 1'b0;
    checks++; if (dac_strobe !== 1'b1) begin failures++; $display("FAIL mute_strobe got=%b exp=1", dac_strobe); end
    checks++; if (dac_out !== {11'h400, 11'h400}) begin failures++; $display("FAIL mute_dac got=%h exp=%h", dac_out, {11'h400, 11'h400}); end
    step(6);
    checks++; if (dac_out !== {11'h400, 11'h400}) begin failures++; $display("FAIL mute_dac_hold got=%h exp=%h", dac_out, {11'h400, 11'h400}); end
    prev = pdm_out;
    for (int i = 0; i < 6; i++) begin
      step(1);
      checks++; if (pdm_out !== ~prev) begin failures++; $display("FAIL mute_alt%0d got=%b exp=%b", i, pdm_out, ~prev); end
      prev = pdm_out;
    end
  endtask

  task automatic test_atten();
    int ones0;
    do_reset();
    atten = 4'd4; s_data = {16'h7FFF, 16'h7FFF}; s_valid = 1'b1;
    step(2);
    s_valid = 1'b0;
    step(2);
    atten = 4'd0;
    checks++; if (dac_out !== {11'h43F, 11'h43F}) begin failures++; $display("FAIL att_dac got=%h exp=%h", dac_out, {11'h43F, 11'h43F}); end
    step(64);
    checks++; if (dac_out !== {11'h43F, 11'h43F}) begin failures++; $display("FAIL att_dac_hold got=%h exp=%h", dac_out, {11'h43F, 11'h43F}); end
    ones0 = 0;
    for (int i = 0; i < 2048; i++) begin
      ones0 += int'(pdm_out[0]);
      step(1);
    end
`ifdef SIDI_AUDIO_SECOND_ORDER_EN
    checks++; if (ones0 < 1086 || ones0 > 1088) begin failures++; $display("FAIL att_density got=%0d exp=1087+-1", ones0); end
`else
    checks++; if (ones0 != 1087) begin failures++; $display("FAIL att_density got=%0d exp=1087", ones0); end
`endif
  endtask

  task automatic test_underrun();
    do_reset();
    step(12);
    checks++; if (underrun_cnt !== 8'd3) begin failures++; $display("FAIL ur_three got=%0d exp=3", underrun_cnt); end
    checks++; if (dac_out !== {11'h400, 11'h400}) begin failures++; $display("FAIL ur_dac_hold got=%h exp=%h", dac_out, {11'h400, 11'h400}); end
    step(4 * 300);
    checks++; if (underrun_cnt !== 8'd255) begin failures++; $display("FAIL ur_saturate got=%0d exp=255", underrun_cnt); end
    step(8);
    checks++; if (underrun_cnt !== 8'd255) begin failures++; $display("FAIL ur_stay got=%0d exp=255", underrun_cnt); end
  endtask

  task automatic test_accept_on_tick();
    do_reset();
    step(3);
    s_data = {16'h4000, 16'hC000}; s_valid = 1'b1;
    step(1);
    s_valid = 1'b0;
    checks++; if (underrun_cnt !== 8'd1) begin failures++; $display("FAIL aot_underrun got=%0d exp=1", underrun_cnt); end
    checks++; if (dac_strobe !== 1'b0) begin failures++; $display("FAIL aot_no_strobe got=%b exp=0", dac_strobe); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL aot_ready got=%b exp=0", s_ready); end
    step(4);
    checks++; if (dac_strobe !== 1'b1) begin failures++; $display("FAIL aot_strobe got=%b exp=1", dac_strobe); end
    checks++; if (dac_out !== {11'h600, 11'h200}) begin failures++; $display("FAIL aot_dac got=%h exp=%h", dac_out, {11'h600, 11'h200}); end
    checks++; if (underrun_cnt !== 8'd1) begin failures++; $display("FAIL aot_underrun_hold got=%0d exp=1", underrun_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_backpressure();
    test_mute();
    test_atten();
    test_underrun();
    test_accept_on_tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
